// File: rtl/wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_stage_if                                                     |
// | Purpose  : MEM->WB pipeline fields in, register-file write port out.       |
// |            Optional macro WB_BYPASS_EN adds the fwd_* forwarding signals.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // MEM stage -> WB stage
  logic              mem_valid;
  logic              mem_regWrite;
  logic              mem_memToReg;
  logic [2:0]        mem_loadType;
  logic [DATA_W-1:0] mem_aluResult;
  logic [DATA_W-1:0] mem_readData;
  logic [REG_AW-1:0] mem_writeReg;

  // Hazard unit
  logic              stall;
  logic              flush;
  logic              mem_ready;

  // Register-file write port and status
  logic              regWrite;
  logic [REG_AW-1:0] WriteReg;
  logic [DATA_W-1:0] writeData;
  logic [31:0]       retired;

`ifdef WB_BYPASS_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    input  mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
    input  mem_aluResult, mem_readData, mem_writeReg, stall, flush,
    output mem_ready, regWrite, WriteReg, writeData, retired,
    output fwd_valid, fwd_reg, fwd_data
  );

  modport slave (
    output mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
    output mem_aluResult, mem_readData, mem_writeReg, stall, flush,
    input  mem_ready, regWrite, WriteReg, writeData, retired,
    input  fwd_valid, fwd_reg, fwd_data
  );
`else
  modport master (
    input  mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
    input  mem_aluResult, mem_readData, mem_writeReg, stall, flush,
    output mem_ready, regWrite, WriteReg, writeData, retired
  );

  modport slave (
    output mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
    output mem_aluResult, mem_readData, mem_writeReg, stall, flush,
    input  mem_ready, regWrite, WriteReg, writeData, retired
  );
`endif

endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_stage                                                        |
// | Purpose  : Write-back stage: MEM/WB register, load extension, r0-guarded   |
// |            register-file write, retired counter. Macro: WB_BYPASS_EN.      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.master        bus
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [2:0]        loadtype_q, loadtype_d;
  logic [DATA_W-1:0] alu_q,      alu_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic [REG_AW-1:0] wreg_q,     wreg_d;
  logic [31:0]       retired_q,  retired_d;

  logic              advance;
  logic              wr_en;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wb_data;

  // The WB instruction leaves the stage only on a cycle that neither holds nor squashes it.
  assign advance = ~bus.stall & ~bus.flush;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    loadtype_d = loadtype_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    wreg_d     = wreg_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d    = bus.mem_valid;
      regwrite_d = bus.mem_regWrite;
      memtoreg_d = bus.mem_memToReg;
      loadtype_d = bus.mem_loadType;
      alu_d      = bus.mem_aluResult;
      rdata_d    = bus.mem_readData;
      wreg_d     = bus.mem_writeReg;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (valid_q && advance) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      loadtype_q <= 3'b000;
      alu_q      <= '0;
      rdata_q    <= '0;
      wreg_q     <= '0;
      retired_q  <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      loadtype_q <= loadtype_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      wreg_q     <= wreg_d;
      retired_q  <= retired_d;
    end
  end

  // Little-endian lane select; a misaligned halfword simply ignores address bit 0.
  always_comb begin
    load_byte = 8'h00;
    case (alu_q[1:0])
      2'd0:    load_byte = rdata_q[7:0];
      2'd1:    load_byte = rdata_q[15:8];
      2'd2:    load_byte = rdata_q[23:16];
      default: load_byte = rdata_q[31:24];
    endcase
  end

  assign load_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    case (loadtype_q)
      LD_LH:   load_data = {{(DATA_W-16){load_half[15]}}, load_half};
      LD_LHU:  load_data = {{(DATA_W-16){1'b0}}, load_half};
      LD_LB:   load_data = {{(DATA_W-8){load_byte[7]}}, load_byte};
      LD_LBU:  load_data = {{(DATA_W-8){1'b0}}, load_byte};
      LD_LW:   load_data = rdata_q;
      default: load_data = rdata_q;
    endcase
  end

  assign wb_data = memtoreg_q ? load_data : alu_q;

  // Gating by stall makes a held write fire exactly once, on the release cycle.
  assign wr_en = valid_q & regwrite_q & (wreg_q != '0) & advance;

  assign bus.mem_ready = ~bus.stall;
  assign bus.regWrite  = wr_en;
  assign bus.WriteReg  = wreg_q;
  assign bus.writeData = wb_data;
  assign bus.retired   = retired_q;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = wr_en;
  assign bus.fwd_reg   = wreg_q;
  assign bus.fwd_data  = wb_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_stage                                                     |
// | Purpose  : Directed and random checks of wb_stage against a reference      |
// |            model of the write-back rules. Macro: WB_BYPASS_EN.             |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_wb_stage;

  logic clk;
  logic rst;

  wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] a;
    logic [31:0] rd;
    logic [4:0]  wr;
    bit          known;
  } wb_t;

  wb_t         m;
  logic [31:0] exp_ret;
  int          checks;
  int          errors;
  int          wr_seen;

  // Inputs currently applied (the model consumes these at the next posedge).
  logic        c_v, c_rw, c_m2r, c_st, c_fl;
  logic [2:0]  c_lt;
  logic [31:0] c_a, c_rd;
  logic [4:0]  c_wr;

  function automatic logic [31:0] ref_data(input wb_t s);
    logic [31:0] b;
    logic [31:0] h;
    if (!s.m2r) return s.a;
    b = (s.rd >> (8 * s.a[1:0])) & 32'hFF;
    h = (s.rd >> (16 * s.a[1])) & 32'hFFFF;
    case (s.lt)
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      default: return s.rd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.valid = 0; m.rw = 0; m.m2r = 0; m.lt = 0;
    m.a = 0; m.rd = 0; m.wr = 0; m.known = 1;
    exp_ret = 0;
  endtask

  // Drive on the falling edge, then compare the combinational outputs with the model.
  task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] rd, input logic [4:0] wr,
                        input logic st, input logic fl);
    logic exp_rw;
    @(negedge clk);
    c_v = v; c_rw = rw; c_m2r = m2r; c_lt = lt; c_a = a; c_rd = rd; c_wr = wr;
    c_st = st; c_fl = fl;
    bus.mem_valid = v; bus.mem_regWrite = rw; bus.mem_memToReg = m2r;
    bus.mem_loadType = lt; bus.mem_aluResult = a; bus.mem_readData = rd;
    bus.mem_writeReg = wr; bus.stall = st; bus.flush = fl;
    #1;
    exp_rw = rst && m.valid && m.rw && (m.wr != 0) && !st && !fl;
    if (bus.regWrite === 1'b1) wr_seen++;
    chk("regWrite", {31'd0, bus.regWrite}, {31'd0, exp_rw});
    chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, !st});
    chk("retired", bus.retired, exp_ret);
    if (m.known) begin
      chk("WriteReg", {27'd0, bus.WriteReg}, {27'd0, m.wr});
      chk("writeData", bus.writeData, ref_data(m));
    end
`ifdef WB_BYPASS_EN
    chk("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, bus.regWrite});
    chk("fwd_reg", {27'd0, bus.fwd_reg}, {27'd0, bus.WriteReg});
    chk("fwd_data", bus.fwd_data, bus.writeData);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (m.valid && !c_st && !c_fl) exp_ret = exp_ret + 32'd1;
      if (c_fl) begin
        m.valid = 0;
        m.known = 0;
      end else if (!c_st) begin
        m.valid = c_v; m.rw = c_rw; m.m2r = c_m2r; m.lt = c_lt;
        m.a = c_a; m.rd = c_rd; m.wr = c_wr; m.known = 1;
      end
    end
  endtask

  task automatic bubble(input logic st, input logic fl);
    set_in(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, st, fl);
  endtask

  logic [31:0] ret_snap;

  initial begin
    checks = 0; errors = 0; wr_seen = 0;
    model_reset();
    rst = 1'b0;
    c_st = 0; c_fl = 0;

    // Reset state
    bubble(0, 0); tick();
    bubble(0, 0);
    chk("rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("rst_writeData", bus.writeData, 32'h0);
    tick();
    #1 rst = 1'b1;

    // ALU write to r5
    set_in(1, 1, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 0); tick();
    bubble(0, 0);
    chk("alu_rw", {31'd0, bus.regWrite}, 32'd1);
    chk("alu_reg", {27'd0, bus.WriteReg}, 32'd5);
    chk("alu_data", bus.writeData, 32'h0000_1234);
    tick();
    bubble(0, 0);
    chk("alu_retired", bus.retired, 32'd1);
    tick();

    // Load extension chain, each checked while the next is captured
    set_in(1, 1, 1, 3'd3, 32'h100, 32'h8077_F0A5, 5'd3, 0, 0); tick();
    set_in(1, 1, 1, 3'd4, 32'h101, 32'h8077_F0A5, 5'd3, 0, 0);
    chk("LB0", bus.writeData, 32'hFFFF_FFA5); tick();
    set_in(1, 1, 1, 3'd1, 32'h102, 32'h8077_F0A5, 5'd3, 0, 0);
    chk("LBU1", bus.writeData, 32'h0000_00F0); tick();
    set_in(1, 1, 1, 3'd2, 32'h103, 32'h8077_F0A5, 5'd3, 0, 0);
    chk("LH2", bus.writeData, 32'hFFFF_8077); tick();
    set_in(1, 1, 1, 3'd0, 32'h100, 32'h8077_F0A5, 5'd3, 0, 0);
    chk("LHU3", bus.writeData, 32'h0000_8077); tick();
    bubble(0, 0);
    chk("LW", bus.writeData, 32'h8077_F0A5); tick();

    // r0 suppression still retires
    set_in(1, 1, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0); tick();
    ret_snap = exp_ret;
    bubble(0, 0);
    chk("r0_rw", {31'd0, bus.regWrite}, 32'd0); tick();
    bubble(0, 0);
    chk("r0_retired", bus.retired, ret_snap + 32'd1); tick();

    // Stall for 3 cycles with changing inputs, exactly one write on release
    set_in(1, 1, 0, 3'd0, 32'h0000_0077, 32'h0, 5'd7, 0, 0); tick();
    wr_seen = 0;
    ret_snap = exp_ret;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 3'd0, $urandom, $urandom, 5'($urandom), 1, 0);
      chk("stall_reg", {27'd0, bus.WriteReg}, 32'd7);
      chk("stall_data", bus.writeData, 32'h77);
      tick();
    end
    bubble(0, 0);
    chk("rel_data", bus.writeData, 32'h77); tick();
    bubble(0, 0); tick();
    chk("stall_writes", wr_seen, 1);
    bubble(0, 0);
    chk("stall_retired", bus.retired, ret_snap + 32'd1); tick();

    // Stall and flush together on a pending write to r9
    set_in(1, 1, 0, 3'd0, 32'h99, 32'h0, 5'd9, 0, 0); tick();
    ret_snap = exp_ret;
    wr_seen = 0;
    bubble(1, 1); tick();
    bubble(0, 0); tick();
    chk("flush_writes", wr_seen, 0);
    bubble(0, 0);
    chk("flush_retired", bus.retired, ret_snap); tick();

    // Reset while a write is held by stall
    set_in(1, 1, 0, 3'd0, 32'h55, 32'h0, 5'd7, 0, 0); tick();
    bubble(1, 0); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("arst_retired", bus.retired, 32'd0);
    model_reset();
    bubble(1, 0); tick();
    #1 rst = 1'b1;
    wr_seen = 0;
    bubble(0, 0); tick();
    bubble(0, 0); tick();
    chk("arst_writes", wr_seen, 0);

    // Retired counter wrap
    set_in(1, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0); tick();
    #1 force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    bubble(0, 0); tick();
    bubble(0, 0);
    chk("wrap", bus.retired, 32'h0); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
             $urandom, $urandom, 5'($urandom_range(0, 7)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the pipelined core; the initiator side of the register-file write port.
- Registers the MEM/WB pipeline fields and forms the load-extended or ALU write-back value.
- Drives regWrite/WriteReg/writeData into the register file, which commits on its posedge.
- Handles stall and flush, suppresses writes to r0, and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- mem_valid  in  1  MEM stage presents a valid instruction.
- mem_regWrite  in  1  the instruction writes a register.
- mem_memToReg  in  1  1 = write loaded data, 0 = write the ALU result.
- mem_loadType  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes are treated as LW.
- mem_aluResult  in  32  ALU result; also the load address.
- mem_readData  in  32  raw 32-bit data-memory word.
- mem_writeReg  in  5  destination register.
- stall  in  1  hazard-unit hold request.
- flush  in  1  squash the instruction in WB.
- mem_ready  out  1  equals !stall; the MEM stage advances only when 1.
- regWrite  out  1  register-file write enable.
- WriteReg  out  5  register-file write address.
- writeData  out  32  register-file write data.
- retired  out  32  count of retired valid instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_valid=0, all WB fields=0, retired=0.
  - Outputs during reset: regWrite=0, WriteReg=0, writeData=0.
- Posedge update priority is flush > stall > capture:
  - flush=1: wb_valid<=0; the other fields are don't-care.
  - stall=1 and flush=0: all WB fields hold.
  - Otherwise: wb_valid<=mem_valid and every mem_* field is captured.
- Latency:
  - Capture at posedge N; regWrite/WriteReg/writeData are valid combinationally during cycle N..N+1.
  - The register file commits at posedge N+1.
- Write enable:
  - regWrite = wb_valid & wb_regWrite & (wb_writeReg != 0) & !stall & !flush.
  - Gating with stall guarantees exactly one write when stall releases.
- WriteReg = wb_writeReg, always, whether or not regWrite is asserted.
- writeData:
  - When wb_memToReg=0: writeData = wb_aluResult.
  - When wb_memToReg=1, little-endian extraction:
    - Byte lane = wb_aluResult[1:0]; LB sign-extends, LBU zero-extends.
    - Half lane = wb_aluResult[1] (bit 0 ignored, no trap); LH sign-extends, LHU zero-extends.
    - LW passes readData unchanged.
- retired:
  - Increments by 1 on a posedge where wb_valid=1, stall=0 and flush=0.
  - Stores and branches count; an instruction squashed by flush does not count.
  - Wraps from 0xFFFFFFFF to 0.
- Simultaneous stall+flush: flush wins; the instruction is dropped and no write occurs.
- Reset mid-stall: the held instruction is discarded and no write is issued after reset releases.
- Writes to r0 are never issued; the register file's r0 stays 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: three extra outputs are added for forwarding to EX/ID:
  - fwd_valid (1) = regWrite.
  - fwd_reg (5) = WriteReg.
  - fwd_data (32) = writeData.
  - This lets decode bypass a same-cycle write that the register file has not yet committed.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then ALU op: rst=0→1; mem_valid=1, regWrite=1, memToReg=0, aluResult=0x0000_1234, writeReg=5 → next cycle regWrite=1, WriteReg=5, writeData=0x1234, and retired=1 after the following posedge.
- Loads:
  - readData=0x8077_F0A5 with LB, addr[1:0]=0 → 0xFFFF_FFA5.
  - LBU, addr=1 → 0x0000_00F0.
  - LH, addr=2 → 0xFFFF_8077.
  - LHU, addr=3 → 0x0000_8077.
  - LW → 0x8077_F0A5.
- r0 suppression: valid write with writeReg=0, data 0xDEAD_BEEF → regWrite stays 0; retired still increments.
- Stall: capture a write to r7, then hold stall=1 for 3 cycles while the mem_* inputs change → regWrite=0 and fields held; on release regWrite=1 for exactly 1 cycle with the original data; retired +1 once.
- Flush vs stall: stall=1 and flush=1 in the same cycle on a pending write to r9 → no write to r9 and retired unchanged.
- Counter wrap: force retired to 0xFFFF_FFFF, retire 1 instruction → 0. With WB_BYPASS_EN defined: fwd_* mirror regWrite/WriteReg/writeData every cycle.
